// File: rtl/axis_skid_fifo.sv
// -----------------------------------------------------------------------------
// axis_skid_fifo
//
// AXI4-Stream FIFO with first-word fall-through.
// DEPTH entries of {tdata, tuser, tlast} sit in a circular buffer. The head
// entry drives m_tdata/m_tuser/m_tlast directly. m_tvalid, s_tready, level and
// s_afull are all registered.
//
// Parameters:
//   DATA_WIDTH   tdata width (>=1)
//   USER_WIDTH   tuser width (>=1)
//   DEPTH        storage entries, power of two, >=2
//   AFULL_LEVEL  occupancy at or above which s_afull asserts (1..DEPTH)
//
// Ports:
//   aclk, areset    clock; synchronous active-high reset
//   aclken          clock enable, low freezes all state (reset still applies)
//   s_t*            slave side: tdata, tuser, tlast, tvalid in; tready out
//   m_t*            master side: tdata, tuser, tlast, tvalid out; tready in
//   level           number of stored entries
//   s_afull         level >= AFULL_LEVEL
//   pkt_count       stored beats with tlast=1; present only when the macro
//                   AXIS_SKID_FIFO_PKTCNT_EN is defined
// -----------------------------------------------------------------------------
module axis_skid_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         aclken,
  input  logic [DATA_WIDTH-1:0]        s_tdata,
  input  logic [USER_WIDTH-1:0]        s_tuser,
  input  logic                         s_tlast,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic [USER_WIDTH-1:0]        m_tuser,
  output logic                         m_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         s_afull
`ifdef AXIS_SKID_FIFO_PKTCNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = DATA_WIDTH + USER_WIDTH + 1;

  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_THR  = LVL_W'(AFULL_LEVEL);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  // ST_HOLD keeps s_tready low for one qualified edge after reset release
  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t state;
  state_t state_next;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic               push;
  logic               pop;
  logic [LVL_W-1:0]   level_next;
  logic               s_tready_next;
  logic               m_tvalid_next;
  logic               s_afull_next;

  always_comb begin
    push = aclken & s_tvalid & s_tready;
    pop  = aclken & m_tvalid & m_tready;
  end

  // Next-state and registered-output computation
  always_comb begin
    state_next    = state;
    level_next    = level;
    s_tready_next = 1'b0;

    if (push && !pop) begin
      level_next = level + LVL_ONE;
    end else if (pop && !push) begin
      level_next = level - LVL_ONE;
    end

    m_tvalid_next = (level_next != '0);
    s_afull_next  = (level_next >= AFULL_THR);

    case (state)
      ST_HOLD: begin
        state_next    = ST_RUN;
        s_tready_next = 1'b0;
      end
      ST_RUN: begin
        // based on next level, so a pop while full cannot admit a push
        // in the same cycle; ready returns on the following cycle
        s_tready_next = (level_next != FULL_LEVEL);
      end
      default: begin
        state_next    = ST_HOLD;
        s_tready_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= ST_HOLD;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      m_tvalid <= 1'b0;
      s_tready <= 1'b0;
      s_afull  <= 1'b0;
    end else if (aclken) begin
      state    <= state_next;
      level    <= level_next;
      m_tvalid <= m_tvalid_next;
      s_tready <= s_tready_next;
      s_afull  <= s_afull_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge aclk) begin
    if (!areset && push) begin
      mem[wr_ptr] <= {s_tdata, s_tuser, s_tlast};
    end
  end

  always_comb begin
    {m_tdata, m_tuser, m_tlast} = mem[rd_ptr];
  end

`ifdef AXIS_SKID_FIFO_PKTCNT_EN
  logic             pkt_in;
  logic             pkt_out;
  logic [LVL_W-1:0] pkt_next;

  always_comb begin
    pkt_in   = push & s_tlast;
    pkt_out  = pop & m_tlast;
    pkt_next = pkt_count;
    if (pkt_in && !pkt_out) begin
      pkt_next = pkt_count + LVL_ONE;
    end else if (pkt_out && !pkt_in) begin
      pkt_next = pkt_count - LVL_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_count <= '0;
    end else if (aclken) begin
      pkt_count <= pkt_next;
    end
  end
`endif

endmodule
